// File: rtl/aes_ctrl_pkg.sv
// Shared types and widths for the AES round controller.
// Stage indices double as bit positions in the per-stage buses.
package aes_ctrl_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 128;
  localparam int NUM_STAGES = 4;
  localparam int CNT_W      = 8;

  typedef enum logic [1:0] {
    SUB    = 2'd0,
    SHIFT  = 2'd1,
    MIX    = 2'd2,
    ADDKEY = 2'd3
  } stage_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } ctrl_state_e;

  function automatic logic [NUM_STAGES-1:0] stage_onehot(input stage_e s);
    logic [NUM_STAGES-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Stage handshake and shared-SRAM bus between the round controller and its stages.
// master = controller side, slave = stage/SRAM side.
interface aes_round_ctrl_if;
  import aes_ctrl_pkg::*;

  logic [NUM_STAGES-1:0]        stage_finished;
  logic [NUM_STAGES-1:0]        stage_enable;
  logic [NUM_STAGES-1:0]        stage_sram_read;
  logic [NUM_STAGES-1:0]        stage_sram_write;
  logic [NUM_STAGES*ADDR_W-1:0] stage_sram_addr;
  logic [NUM_STAGES*DATA_W-1:0] stage_sram_wdata;
  logic                         sram_read;
  logic                         sram_write;
  logic [ADDR_W-1:0]            sram_addr;
  logic [DATA_W-1:0]            sram_wdata;

  modport master (
    input  stage_finished, stage_sram_read, stage_sram_write,
           stage_sram_addr, stage_sram_wdata,
    output stage_enable, sram_read, sram_write, sram_addr, sram_wdata
  );

  modport slave (
    output stage_finished, stage_sram_read, stage_sram_write,
           stage_sram_addr, stage_sram_wdata,
    input  stage_enable, sram_read, sram_write, sram_addr, sram_wdata
  );

endinterface

// File: rtl/aes_stage_timer.sv
// Loadable up-counter used for both the WAIT timeout and the GAP delay.
// load starts the count at 1 so expire flags the LIMIT-th cycle of the phase.
module aes_stage_timer
  import aes_ctrl_pkg::*;
#(
  parameter int LIMIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)       count <= '0;
    else if (load) count <= CNT_W'(1);
    else if (en)   count <= count + CNT_W'(1);
  end

  assign expire = (count == LIMIT_C);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: issues stage enables round by round, waits for each
// stage to finish, and grants the shared SRAM port to the active stage.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  aes_round_ctrl_if.master      bus,
  output logic [3:0]            round_num,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  ctrl_state_e           state;
  stage_e                stage;
  stage_e                nxt_stage;
  logic [3:0]            nxt_round;
  logic                  last_op;
  logic                  granted;
  logic                  fin_active;
  logic                  wait_expire;
  logic                  gap_expire;
  logic [NUM_STAGES-1:0] enable_q;

  assign granted    = state inside {ST_ISSUE, ST_WAIT, ST_GAP};
  assign fin_active = bus.stage_finished[stage];
  assign last_op    = (round_num == LAST_ROUND) && (stage == ADDKEY);

  // The final round skips MIX; every ADDKEY closes a round.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    nxt_stage = stage;
    nxt_round = round_num;
    case (stage)
      SUB:     nxt_stage = SHIFT;
      SHIFT:   nxt_stage = (round_num == LAST_ROUND) ? ADDKEY : MIX;
      MIX:     nxt_stage = ADDKEY;
      ADDKEY: begin
        nxt_stage = SUB;
        nxt_round = round_num + 4'd1;
      end
      default: nxt_stage = stage;
    endcase
  end

  aes_stage_timer #(.LIMIT(TIMEOUT)) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (state == ST_ISSUE),
    .en     (state == ST_WAIT),
    .expire (wait_expire)
  );

  aes_stage_timer #(.LIMIT(GAP_CYCLES)) u_gap_timer (
    .clk    (clk),
    .rst    (rst),
    .load   ((state == ST_WAIT) && fin_active),
    .en     (state == ST_GAP),
    .expire (gap_expire)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state     <= ST_IDLE;
      stage     <= ADDKEY;
      round_num <= '0;
      enable_q  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      enable_q <= '0;
      done     <= 1'b0;
      if (granted && abort) begin
        state     <= ST_IDLE;
        round_num <= '0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERROR: begin
            if (start) begin
              state     <= ST_ISSUE;
              stage     <= ADDKEY;
              round_num <= '0;
              enable_q  <= stage_onehot(ADDKEY);
              busy      <= 1'b1;
              error     <= 1'b0;
            end else if (state == ST_DONE) begin
              state <= ST_IDLE;
            end
          end
          ST_ISSUE: state <= ST_WAIT;
          // A finish on the timeout cycle still counts as a finish.
          ST_WAIT: begin
            if (fin_active) begin
              state <= ST_GAP;
            end else if (wait_expire) begin
              state <= ST_ERROR;
              busy  <= 1'b0;
              error <= 1'b1;
            end
          end
          ST_GAP: begin
            if (gap_expire) begin
              if (last_op) begin
                state <= ST_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state     <= ST_ISSUE;
                stage     <= nxt_stage;
                round_num <= nxt_round;
                enable_q  <= stage_onehot(nxt_stage);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.stage_enable = enable_q;

  // Shared SRAM port: only the active stage is visible, and only while sequencing.
  logic              sram_read_c;
  logic              sram_write_c;
  logic [ADDR_W-1:0] sram_addr_c;
  logic [DATA_W-1:0] sram_wdata_c;

  always_comb begin
    sram_read_c  = 1'b0;
    sram_write_c = 1'b0;
    sram_addr_c  = '0;
    sram_wdata_c = '0;
    if (granted) begin
      sram_read_c  = bus.stage_sram_read[stage];
      sram_write_c = bus.stage_sram_write[stage];
      sram_addr_c  = bus.stage_sram_addr[int'(stage)*ADDR_W +: ADDR_W];
      sram_wdata_c = bus.stage_sram_wdata[int'(stage)*DATA_W +: DATA_W];
    end
  end

  assign bus.sram_read  = sram_read_c;
  assign bus.sram_write = sram_write_c;
  assign bus.sram_addr  = sram_addr_c;
  assign bus.sram_wdata = sram_wdata_c;

endmodule
